cpu_eu: RTL and testbench

Execution unit for the 16-bit RISC processor. It receives the control word from `control_unit` and carries it out: 8×16 register file, ALU, program counter, instruction register, and the memory address/data muxes. It returns `ir` and the raw ALU flags N/Z/C to `control_unit`, which registers the flags. It connects to program/data memory, which has combinational read and synchronous write.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cpu_eu_alu.sv | 50 +++++
 rtl/cpu_eu.sv | 71 +++++++
 tb/tb_cpu_eu.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit RISC core: datapath sizes, control-word
// field widths and ALU operation encodings.
package cpu_pkg;

  localparam int WIDTH     = 16;
  localparam int NREGS     = 8;
  localparam int REG_ADR_W = 3;
  localparam int ALU_OP_W  = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_PASS_S = 4'b0000,
    ALU_PASS_R = 4'b0001,
    ALU_INC    = 4'b0010,
    ALU_DEC    = 4'b0011,
    ALU_ADD    = 4'b0100,
    ALU_SUB    = 4'b0101,
    ALU_SHR    = 4'b0110,
    ALU_SHL    = 4'b0111,
    ALU_AND    = 4'b1000,
    ALU_OR     = 4'b1001,
    ALU_XOR    = 4'b1010,
    ALU_NOT    = 4'b1011
  } alu_op_e;

endpackage

// File: rtl/cpu_eu_alu.sv
// Combinational ALU: result Y with N/Z/C flags. C is carry for add/inc,
// borrow for sub/dec, the shifted-out bit for shifts, and 0 otherwise.
module alu
  import cpu_pkg::*;
#(
  parameter int W = cpu_pkg::WIDTH
) (
  input  logic [W-1:0]        r,
  input  logic [W-1:0]        s,
  input  logic [ALU_OP_W-1:0] op,
  output logic [W-1:0]        y,
  output logic                n,
  output logic                z,
  output logic                c
);

  localparam logic [W:0] ONE = (W+1)'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no code path
    // can leave one unassigned and infer a latch.
    y = s;
    c = 1'b0;
    unique case (op)
      ALU_PASS_R: y = r;
      // The 17th bit of a zero-extended sum is the carry; of a difference, the borrow.
      ALU_INC:    {c, y} = {1'b0, s} + ONE;
      ALU_DEC:    {c, y} = {1'b0, s} - ONE;
      ALU_ADD:    {c, y} = {1'b0, r} + {1'b0, s};
      ALU_SUB:    {c, y} = {1'b0, r} - {1'b0, s};
      ALU_SHR: begin
        y = s >> 1;
        c = s[0];
      end
      ALU_SHL: begin
        y = s << 1;
        c = s[W-1];
      end
      ALU_AND:    y = r & s;
      ALU_OR:     y = r | s;
      ALU_XOR:    y = r ^ s;
      ALU_NOT:    y = ~s;
      default:    y = s;
    endcase
  end

  assign n = y[W-1];
  assign z = (y == '0);

endmodule

// File: rtl/cpu_eu.sv
// Execution unit: register file, PC, IR, ALU and memory address/data muxes,
// driven by the control word from control_unit.
module cpu_eu
  import cpu_pkg::*;
#(
  parameter int WIDTH = cpu_pkg::WIDTH,
  parameter int NREGS = cpu_pkg::NREGS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_ADR_W-1:0] W_Adr,
  input  logic [REG_ADR_W-1:0] R_Adr,
  input  logic [REG_ADR_W-1:0] S_Adr,
  input  logic                 adr_sel,
  input  logic                 s_sel,
  input  logic                 pc_ld,
  input  logic                 pc_inc,
  input  logic                 pc_sel,
  input  logic                 ir_ld,
  input  logic                 rw_en,
  input  logic [ALU_OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0]     D_in,
  output logic [WIDTH-1:0]     Address,
  output logic [WIDTH-1:0]     D_out,
  output logic [WIDTH-1:0]     ir,
  output logic                 N,
  output logic                 Z,
  output logic                 C
);

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] r_bus;
  logic [WIDTH-1:0] s_bus;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] rel_off;

  assign r_bus   = rf[R_Adr];
  assign s_bus   = rf[S_Adr];
  assign Address = adr_sel ? r_bus : pc;
  assign D_out   = s_bus;
  assign rel_off = {{(WIDTH-8){ir[7]}}, ir[7:0]};

  alu #(.W(WIDTH)) u_alu (
    .r  (r_bus),
    .s  (s_bus),
    .op (alu_op),
    .y  (alu_y),
    .n  (N),
    .z  (Z),
    .c  (C)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0;
      ir <= '0;
      // NOTE: the register file is architecturally cleared by reset, so it is
      // built from flops with a reset loop rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here make every read in this block see
      // pre-edge state, which gives write-then-read-old with no bypass.
      if (rw_en) rf[W_Adr] <= s_sel ? D_in : alu_y;
      if (pc_ld)       pc <= pc_sel ? s_bus : pc + rel_off;
      else if (pc_inc) pc <= pc + WIDTH'(1);
      if (ir_ld) ir <= D_in;
    end
  end

endmodule

// File: tb/tb_cpu_eu.sv
// Self-checking bench for cpu_eu: directed scenarios plus randomized control
// words, all checked against an arithmetic reference model of the unit.
module tb_cpu_eu;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic        adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, rw_en;
  logic [3:0]  alu_op;
  logic [15:0] D_in;
  logic [15:0] Address, D_out, ir;
  logic        N, Z, C;

  int vectors = 0;
  int errors  = 0;

  // Reference state, kept as plain integers.
  int m_rf [8];
  int m_pc;
  int m_ir;

  cpu_eu dut (
    .clk(clk), .reset(reset), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_sel(pc_sel), .ir_ld(ir_ld), .rw_en(rw_en), .alu_op(alu_op),
    .D_in(D_in), .Address(Address), .D_out(D_out), .ir(ir),
    .N(N), .Z(Z), .C(C)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Returns {C, Y[15:0]} for the given operation on unsigned operands.
  function automatic logic [16:0] ref_alu(input int op, input int r, input int s);
    int y, c, t;
    logic [15:0] rv, sv;
    rv = 16'(r);
    sv = 16'(s);
    c  = 0;
    case (op)
      0:  y = s;
      1:  y = r;
      2:  begin t = s + 1; y = t % 65536; c = (t > 65535) ? 1 : 0; end
      3:  begin c = (s < 1) ? 1 : 0; y = (s + 65535) % 65536; end
      4:  begin t = r + s; y = t % 65536; c = (t > 65535) ? 1 : 0; end
      5:  begin c = (r < s) ? 1 : 0; y = (r - s + 65536) % 65536; end
      6:  begin y = s / 2; c = s % 2; end
      7:  begin y = (s * 2) % 65536; c = s / 32768; end
      8:  y = int'(rv & sv);
      9:  y = int'(rv | sv);
      10: y = int'(rv ^ sv);
      11: y = 65535 - s;
      default: y = s;
    endcase
    return {c[0], y[15:0]};
  endfunction

  task automatic idle();
    W_Adr = 0; R_Adr = 0; S_Adr = 0;
    adr_sel = 0; s_sel = 0; pc_ld = 0; pc_inc = 0; pc_sel = 0;
    ir_ld = 0; rw_en = 0; alu_op = 0; D_in = 0;
  endtask

  // Advances one clock and applies the same edge to the reference model.
  task automatic tick();
    logic [16:0] e;
    int s_val, off;
    e     = ref_alu(int'(alu_op), m_rf[R_Adr], m_rf[S_Adr]);
    s_val = m_rf[S_Adr];
    off   = (m_ir % 256 >= 128) ? (m_ir % 256) - 256 : m_ir % 256;
    @(posedge clk);
    if (!reset) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_pc = 0;
      m_ir = 0;
    end else begin
      if (rw_en) m_rf[W_Adr] = s_sel ? int'(D_in) : int'(e[15:0]);
      if (pc_ld)       m_pc = pc_sel ? s_val : (m_pc + off + 65536) % 65536;
      else if (pc_inc) m_pc = (m_pc + 1) % 65536;
      if (ir_ld) m_ir = int'(D_in);
    end
    #1;
  endtask

  task automatic write_reg(input int a, input int v);
    idle();
    W_Adr = 3'(a); D_in = 16'(v); s_sel = 1; rw_en = 1;
    tick();
    idle();
  endtask

  task automatic set_pc(input int v);
    write_reg(7, v);
    S_Adr = 7; pc_ld = 1; pc_sel = 1;
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    rw_en = 1; D_in = 16'h5555; pc_inc = 1; ir_ld = 1;
    tick(); tick();
    idle();
    #2;
    vectors++;
    if ({Address, D_out, ir} !== 48'h0) begin
      errors++;
      $display("FAIL reset_state got addr=%h dout=%h ir=%h required 0/0/0", Address, D_out, ir);
    end
    vectors++;
    if ({N, Z, C} !== 3'b010) begin
      errors++;
      $display("FAIL reset_flags got NZC=%b required 010", {N, Z, C});
    end
    reset = 1;
  endtask

  task automatic test_fetch();
    idle();
    D_in = 16'hE0C8; ir_ld = 1; pc_inc = 1;
    #2;
    vectors++;
    if (Address !== 16'h0000) begin
      errors++;
      $display("FAIL fetch_addr got %h required 0000", Address);
    end
    tick();
    idle();
    #2;
    vectors++;
    if (ir !== 16'hE0C8 || Address !== 16'h0001) begin
      errors++;
      $display("FAIL fetch_result got ir=%h pc=%h required E0C8/0001", ir, Address);
    end
  endtask

  task automatic test_add_carry();
    write_reg(1, 16'hFFFF);
    write_reg(2, 16'h0001);
    W_Adr = 3; R_Adr = 1; S_Adr = 2; alu_op = 4'b0100; rw_en = 1;
    #2;
    vectors++;
    if ({N, Z, C} !== 3'b011) begin
      errors++;
      $display("FAIL add_flags got NZC=%b required 011", {N, Z, C});
    end
    tick();
    idle();
    S_Adr = 3;
    #2;
    vectors++;
    if (D_out !== 16'h0000) begin
      errors++;
      $display("FAIL add_result got R3=%h required 0000", D_out);
    end
  endtask

  task automatic test_sub_borrow();
    write_reg(1, 16'h0003);
    write_reg(2, 16'h0005);
    W_Adr = 4; R_Adr = 1; S_Adr = 2; alu_op = 4'b0101; rw_en = 1;
    #2;
    vectors++;
    if ({N, Z, C} !== 3'b101) begin
      errors++;
      $display("FAIL sub_flags got NZC=%b required 101", {N, Z, C});
    end
    tick();
    idle();
    S_Adr = 4;
    #2;
    vectors++;
    if (D_out !== 16'hFFFE) begin
      errors++;
      $display("FAIL sub_result got R4=%h required FFFE", D_out);
    end
  endtask

  task automatic test_rel_jump();
    logic [15:0] ir_val [2] = '{16'hF8FC, 16'h127F};
    logic [15:0] exp_pc [2] = '{16'h000C, 16'h008F};
    for (int k = 0; k < 2; k++) begin
      set_pc(16'h0010);
      D_in = ir_val[k]; ir_ld = 1;
      tick();
      idle();
      pc_ld = 1; pc_sel = 0;
      tick();
      idle();
      #2;
      vectors++;
      if (Address !== exp_pc[k]) begin
        errors++;
        $display("FAIL rel_jump%0d got pc=%h required %h", k, Address, exp_pc[k]);
      end
    end
  endtask

  task automatic test_jmp_wrap();
    set_pc(16'hFFFF);
    #2;
    vectors++;
    if (Address !== 16'hFFFF) begin
      errors++;
      $display("FAIL jmp_reg got pc=%h required FFFF", Address);
    end
    pc_inc = 1;
    tick();
    idle();
    #2;
    vectors++;
    if (Address !== 16'h0000) begin
      errors++;
      $display("FAIL pc_wrap got pc=%h required 0000", Address);
    end
    write_reg(2, 16'h1234);
    S_Adr = 2; pc_ld = 1; pc_sel = 1; pc_inc = 1;
    tick();
    idle();
    #2;
    vectors++;
    if (Address !== 16'h1234) begin
      errors++;
      $display("FAIL ld_over_inc got pc=%h required 1234", Address);
    end
  endtask

  task automatic test_mem_ops();
    write_reg(1, 16'h0040);
    write_reg(2, 16'h1234);
    R_Adr = 1; S_Adr = 2; adr_sel = 1;
    #2;
    vectors++;
    if (Address !== 16'h0040 || D_out !== 16'h1234) begin
      errors++;
      $display("FAIL sto got addr=%h dout=%h required 0040/1234", Address, D_out);
    end
    idle();
    R_Adr = 1; adr_sel = 1; W_Adr = 5; s_sel = 1; rw_en = 1; D_in = 16'hBEEF;
    tick();
    idle();
    S_Adr = 5;
    #2;
    vectors++;
    if (D_out !== 16'hBEEF) begin
      errors++;
      $display("FAIL ld got R5=%h required BEEF", D_out);
    end
    // LDI: register takes M[old PC] while the PC advances.
    set_pc(16'h0100);
    W_Adr = 6; s_sel = 1; rw_en = 1; pc_inc = 1; D_in = 16'h00A5;
    tick();
    idle();
    S_Adr = 6;
    #2;
    vectors++;
    if (D_out !== 16'h00A5 || Address !== 16'h0101) begin
      errors++;
      $display("FAIL ldi got R6=%h pc=%h required 00A5/0101", D_out, Address);
    end
    reset = 0;
    W_Adr = 6; s_sel = 1; rw_en = 1; D_in = 16'hAAAA; pc_inc = 1;
    tick();
    reset = 1;
    idle();
    S_Adr = 6;
    #2;
    vectors++;
    if (D_out !== 16'h0000 || Address !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset got R6=%h pc=%h required 0000/0000", D_out, Address);
    end
  endtask

  task automatic test_random();
    logic [16:0] e;
    logic [15:0] exp_addr;
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 39) != 0);
      W_Adr   = 3'($urandom);
      R_Adr   = 3'($urandom);
      S_Adr   = 3'($urandom);
      adr_sel = 1'($urandom);
      s_sel   = 1'($urandom);
      pc_ld   = ($urandom_range(0, 3) == 0);
      pc_inc  = 1'($urandom);
      pc_sel  = 1'($urandom);
      ir_ld   = 1'($urandom);
      rw_en   = ($urandom_range(0, 3) != 0);
      alu_op  = 4'($urandom_range(0, 15));
      D_in    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      #2;
      e        = ref_alu(int'(alu_op), m_rf[R_Adr], m_rf[S_Adr]);
      exp_addr = adr_sel ? 16'(m_rf[R_Adr]) : 16'(m_pc);
      vectors++;
      if (Address !== exp_addr || D_out !== 16'(m_rf[S_Adr]) || ir !== 16'(m_ir)) begin
        errors++;
        $display("FAIL rand_bus[%0d] got addr=%h dout=%h ir=%h required %h/%h/%h",
                 i, Address, D_out, ir, exp_addr, 16'(m_rf[S_Adr]), 16'(m_ir));
      end
      vectors++;
      if ({N, Z, C} !== {e[15], e[15:0] == 16'h0, e[16]}) begin
        errors++;
        $display("FAIL rand_flags[%0d] op=%h got NZC=%b required %b",
                 i, alu_op, {N, Z, C}, {e[15], e[15:0] == 16'h0, e[16]});
      end
      tick();
    end
    reset = 1;
    idle();
  endtask

  initial begin
    foreach (m_rf[i]) m_rf[i] = 0;
    m_pc  = 0;
    m_ir  = 0;
    reset = 0;
    idle();
    @(negedge clk);
    test_reset();
    test_fetch();
    test_add_carry();
    test_sub_borrow();
    test_rel_jump();
    test_jmp_wrap();
    test_mem_ops();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
